// File: rtl/filter_pkg.sv
// -----------------------------------------------------------------------------
// filter_pkg
// Shared definitions for the 9-bit frame word datapath.
//   Word format : bit FRAME_BIT = 1 -> frame byte in bits [7:0]
//                 bit FRAME_BIT = 0 -> gap / terminator word
//   TERM_WORD   : canonical terminator written after every egress frame
//   arb_state_t : frame arbiter states
//   grant_t     : index of the granted receive port (0 or 1)
//   rr_pick     : two-way round-robin choice
// -----------------------------------------------------------------------------
package filter_pkg;

   localparam int                WORD_W    = 9;
   localparam int                FRAME_BIT = 8;
   localparam logic [WORD_W-1:0] TERM_WORD = 9'h000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FWD     = 2'd1,
      TERM    = 2'd2,
      DISCARD = 2'd3
   } arb_state_t;

   typedef logic grant_t;

   // Both requesting: the port that did not win last time gets the grant.
   // Otherwise the single requester wins.
   function automatic grant_t rr_pick(input logic [1:0] req, input grant_t last);
      if (req == 2'b11) begin
         return ~last;
      end
      return req[1];
   endfunction

endpackage

// File: rtl/skid_fifo2.sv
// -----------------------------------------------------------------------------
// skid_fifo2
// Two-entry register FIFO for 9-bit words. Push and pop may occur in the same
// cycle; a push into a full FIFO is accepted only when a pop frees an entry.
//   sys_clk   in   clock
//   sys_rst   in   synchronous reset, active low
//   push      in   write push_data
//   push_data in   word to store
//   pop       in   drop the head word (ignored when empty)
//   head      out  oldest word, 0 when empty
//   count     out  number of stored words (0..2)
// -----------------------------------------------------------------------------
module skid_fifo2
   import filter_pkg::*;
(
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              push,
   input  logic [WORD_W-1:0] push_data,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic [1:0]        count
);

   logic [WORD_W-1:0] word_w [2];
   logic              wr_ptr_reg;
   logic              rd_ptr_reg;
   logic [1:0]        cnt_reg;
   logic              do_push;
   logic              do_pop;

   assign do_pop  = pop & (cnt_reg != 2'd0);
   assign do_push = push & ((cnt_reg != 2'd2) | do_pop);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ent
         logic [WORD_W-1:0] word_reg;

         // Storage needs no reset: an entry is only visible once counted.
         always_ff @(posedge sys_clk) begin
            if (do_push && (wr_ptr_reg == 1'(gi))) begin
               word_reg <= push_data;
            end
         end

         assign word_w[gi] = word_reg;
      end
   endgenerate

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         cnt_reg    <= 2'd0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (do_pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         cnt_reg <= cnt_reg + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = (cnt_reg == 2'd0) ? '0 : word_w[rd_ptr_reg];
   assign count = cnt_reg;

endmodule

// File: rtl/frame_arbiter.sv
// -----------------------------------------------------------------------------
// frame_arbiter
// Merges two first-word-fall-through PHY receive FIFOs into one egress FIFO.
// Whole frames are granted round-robin, idle gap words are dropped, frames that
// reach MAX_LEN bytes are cut short (terminator forced, rest of the frame
// dropped), and per-port frame / truncation counters are kept.
//   sys_clk    in   clock
//   sys_rst    in   synchronous reset, active low
//   rd0_en     out  pop PHY0 RX FIFO head
//   rd0_data   in   PHY0 RX FIFO head word
//   rd0_empty  in   PHY0 RX FIFO empty
//   rd1_en     out  pop PHY1 RX FIFO head
//   rd1_data   in   PHY1 RX FIFO head word
//   rd1_empty  in   PHY1 RX FIFO empty
//   wr_en      out  egress FIFO write strobe
//   wr_data    out  egress word (0 when nothing is pending)
//   wr_full    in   egress FIFO full
//   frm_cnt0   out  complete frames forwarded from PHY0
//   frm_cnt1   out  complete frames forwarded from PHY1
//   trunc_cnt  out  frames truncated at MAX_LEN, both ports
// -----------------------------------------------------------------------------
module frame_arbiter
   import filter_pkg::*;
#(
   parameter int MAX_LEN = 1522,
   parameter int LEN_W   = 11,
   parameter int CNT_W   = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   output logic              rd0_en,
   input  logic [WORD_W-1:0] rd0_data,
   input  logic              rd0_empty,
   output logic              rd1_en,
   input  logic [WORD_W-1:0] rd1_data,
   input  logic              rd1_empty,
   output logic              wr_en,
   output logic [WORD_W-1:0] wr_data,
   input  logic              wr_full,
   output logic [CNT_W-1:0]  frm_cnt0,
   output logic [CNT_W-1:0]  frm_cnt1,
   output logic [CNT_W-1:0]  trunc_cnt
);

   // Per-port views of the receive FIFOs
   logic [WORD_W-1:0] head_w [2];
   logic [1:0]        empty_w;
   logic [1:0]        req_w;
   logic [1:0]        gap_w;

   assign head_w[0] = rd0_data;
   assign head_w[1] = rd1_data;
   assign empty_w   = {rd1_empty, rd0_empty};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_port
         assign req_w[gi] = !empty_w[gi] &  head_w[gi][FRAME_BIT];
         assign gap_w[gi] = !empty_w[gi] & !head_w[gi][FRAME_BIT];
      end
   endgenerate

   // State
   arb_state_t          state_reg, state_next;
   grant_t              grant_reg, grant_next;
   grant_t              last_grant_reg, last_grant_next;
   logic [LEN_W-1:0]    len_reg, len_next;
   logic [1:0][CNT_W-1:0] frm_cnt_reg;
   logic [CNT_W-1:0]    trunc_cnt_reg;

   // Combinational controls
   logic [1:0]          rd_en_c;
   logic [1:0]          frm_inc_c;
   logic                trunc_inc_c;
   logic                skid_push_c;
   logic [WORD_W-1:0]   skid_din_c;
   grant_t              other_w;
   grant_t              pick_w;
   logic [LEN_W-1:0]    len_inc_w;

   // Egress skid
   logic [WORD_W-1:0]   skid_head;
   logic [1:0]          skid_cnt;
   logic                space_w;

   skid_fifo2 u_skid (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .push      (skid_push_c),
      .push_data (skid_din_c),
      .pop       (wr_en),
      .head      (skid_head),
      .count     (skid_cnt)
   );

   assign wr_en   = (skid_cnt != 2'd0) & !wr_full;
   assign wr_data = skid_head;
   // A forwarding pop may proceed if an entry is free now or one drains this cycle.
   assign space_w = (skid_cnt != 2'd2) | wr_en;

   assign other_w   = ~grant_reg;
   assign pick_w    = rr_pick(req_w, last_grant_reg);
   assign len_inc_w = len_reg + LEN_W'(1);

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      len_next        = len_reg;
      rd_en_c         = 2'b00;
      frm_inc_c       = 2'b00;
      trunc_inc_c     = 1'b0;
      skid_push_c     = 1'b0;
      skid_din_c      = TERM_WORD;

      case (state_reg)
         IDLE: begin
            // Gap words are dropped on both ports; frame bytes wait for a grant.
            rd_en_c = gap_w;
            if (req_w != 2'b00) begin
               state_next      = FWD;
               grant_next      = pick_w;
               last_grant_next = pick_w;
               len_next        = '0;
            end
         end

         FWD: begin
            rd_en_c[other_w] = gap_w[other_w];
            if (!empty_w[grant_reg] && space_w) begin
               rd_en_c[grant_reg] = 1'b1;
               skid_push_c        = 1'b1;
               if (head_w[grant_reg][FRAME_BIT]) begin
                  skid_din_c = head_w[grant_reg];
                  len_next   = len_inc_w;
                  if (len_inc_w == LEN_W'(MAX_LEN)) begin
                     state_next = TERM;
                  end
               end else begin
                  // Incoming terminator is replaced by the canonical one.
                  frm_inc_c[grant_reg] = 1'b1;
                  state_next           = IDLE;
               end
            end
         end

         TERM: begin
            rd_en_c[other_w] = gap_w[other_w];
            if (space_w) begin
               skid_push_c = 1'b1;
               trunc_inc_c = 1'b1;
               state_next  = DISCARD;
            end
         end

         DISCARD: begin
            // Drain the rest of the oversize frame, including its terminator.
            rd_en_c[other_w] = gap_w[other_w];
            if (!empty_w[grant_reg]) begin
               rd_en_c[grant_reg] = 1'b1;
               if (!head_w[grant_reg][FRAME_BIT]) begin
                  state_next = IDLE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // No pops while reset is held so reset cannot swallow FIFO words.
   assign rd0_en = rd_en_c[0] & sys_rst;
   assign rd1_en = rd_en_c[1] & sys_rst;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         len_reg        <= '0;
         frm_cnt_reg    <= '0;
         trunc_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         len_reg        <= len_next;
         for (int i = 0; i < 2; i++) begin
            if (frm_inc_c[i]) begin
               frm_cnt_reg[i] <= frm_cnt_reg[i] + CNT_W'(1);
            end
         end
         if (trunc_inc_c) begin
            trunc_cnt_reg <= trunc_cnt_reg + CNT_W'(1);
         end
      end
   end

   assign frm_cnt0  = frm_cnt_reg[0];
   assign frm_cnt1  = frm_cnt_reg[1];
   assign trunc_cnt = trunc_cnt_reg;

endmodule

// File: tb/tb_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_frame_arbiter
// Scoreboard bench for frame_arbiter. Stimulus builds frames at the frame
// level; the expected egress words of each frame (bytes cut at MAX_LEN, then
// 9'h000) go into a per-port queue. A monitor pops and compares whenever
// wr_en is seen. The source of each egress frame is taken from an expected
// grant-order queue when one is given, otherwise from bit 7 of the first
// byte, which the generator sets to the port number.
// -----------------------------------------------------------------------------
module tb_frame_arbiter;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = 11;
   localparam int CNT_W   = 16;
   localparam int BUDGET  = 20000;

   logic              sys_clk   = 1'b0;
   logic              sys_rst   = 1'b0;
   logic              rd0_en;
   logic [8:0]        rd0_data  = 9'h000;
   logic              rd0_empty = 1'b1;
   logic              rd1_en;
   logic [8:0]        rd1_data  = 9'h000;
   logic              rd1_empty = 1'b1;
   logic              wr_en;
   logic [8:0]        wr_data;
   logic              wr_full   = 1'b0;
   logic [CNT_W-1:0]  frm_cnt0;
   logic [CNT_W-1:0]  frm_cnt1;
   logic [CNT_W-1:0]  trunc_cnt;

   frame_arbiter #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .rd0_en    (rd0_en),
      .rd0_data  (rd0_data),
      .rd0_empty (rd0_empty),
      .rd1_en    (rd1_en),
      .rd1_data  (rd1_data),
      .rd1_empty (rd1_empty),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_full   (wr_full),
      .frm_cnt0  (frm_cnt0),
      .frm_cnt1  (frm_cnt1),
      .trunc_cnt (trunc_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   // Input FIFO contents, per-port staging, expected egress per port
   logic [8:0] q0[$], q1[$], stage0[$], stage1[$], exp0[$], exp1[$];
   int         ord_q[$];
   int         total = 0, bad = 0;
   int         cur_src = -1;
   bit         in_reset = 1'b1;
   int         full_mode = 0;      // 0 never full, 1 held full, 2 random
   bit         rand_stall = 1'b0;
   int         pops0 = 0, pops1 = 0, writes = 0;
   int         frm_exp0 = 0, frm_exp1 = 0, trunc_exp = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s got=%0h required=%0h", name, got, req);
      end
   endtask

   // Expected egress: first MAX_LEN bytes, then the terminator. A frame that
   // reaches MAX_LEN bytes counts as truncated, otherwise as forwarded.
   task automatic build_frame(input int port, input int n);
      logic [8:0] w;
      for (int i = 0; i < n; i++) begin
         w = {1'b1, 1'(port), 7'($urandom)};
         if (port == 0) stage0.push_back(w); else stage1.push_back(w);
         if (i < MAX_LEN) begin
            if (port == 0) exp0.push_back(w); else exp1.push_back(w);
         end
      end
      w = {1'b0, 8'($urandom)};
      if (port == 0) stage0.push_back(w); else stage1.push_back(w);
      if (port == 0) exp0.push_back(9'h000); else exp1.push_back(9'h000);
      if (n >= MAX_LEN) trunc_exp++;
      else if (port == 0) frm_exp0++;
      else frm_exp1++;
   endtask

   task automatic feed(input int port, input int k);
      for (int i = 0; i < k; i++) begin
         if (port == 0) begin
            if (stage0.size() > 0) q0.push_back(stage0.pop_front());
         end else begin
            if (stage1.size() > 0) q1.push_back(stage1.pop_front());
         end
      end
   endtask

   task automatic add_gaps(input int port, input int k);
      for (int i = 0; i < k; i++) begin
         if (port == 0) q0.push_back({1'b0, 8'($urandom)});
         else q1.push_back({1'b0, 8'($urandom)});
      end
   endtask

   task automatic wait_drain(input string tag);
      int n = 0;
      while ((q0.size() + q1.size() + exp0.size() + exp1.size() +
              stage0.size() + stage1.size()) != 0 && n < BUDGET) begin
         @(posedge sys_clk);
         n++;
      end
      repeat (3) @(posedge sys_clk);
      #3;
      total++;
      if (n >= BUDGET) begin
         bad++;
         $display("FAIL drain_%s left=%0d required=0", tag,
                  q0.size() + q1.size() + exp0.size() + exp1.size());
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_frm_cnt0"}, 32'(frm_cnt0), 32'(frm_exp0 % (1 << CNT_W)));
      chk({tag, "_frm_cnt1"}, 32'(frm_cnt1), 32'(frm_exp1 % (1 << CNT_W)));
      chk({tag, "_trunc_cnt"}, 32'(trunc_cnt), 32'(trunc_exp % (1 << CNT_W)));
   endtask

   // Models the two FWFT receive FIFOs and the egress full flag.
   initial begin : drive
      bit p0, p1, e0, e1;
      forever begin
         @(negedge sys_clk);
         p0 = rd0_en; p1 = rd1_en; e0 = rd0_empty; e1 = rd1_empty;
         if (p0) chk("rd0_en_when_empty", 32'(e0), 32'd0);
         if (p1) chk("rd1_en_when_empty", 32'(e1), 32'd0);
         @(posedge sys_clk);
         #1;
         if (p0 && !e0) begin pops0++; if (q0.size() > 0) void'(q0.pop_front()); end
         if (p1 && !e1) begin pops1++; if (q1.size() > 0) void'(q1.pop_front()); end
         rd0_empty = (q0.size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
         rd1_empty = (q1.size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
         rd0_data  = (q0.size() > 0) ? q0[0] : 9'h000;
         rd1_data  = (q1.size() > 0) ? q1[0] : 9'h000;
         wr_full   = (full_mode == 1) || (full_mode == 2 && $urandom_range(0, 3) == 0);
      end
   end

   // Monitor: compares each egress write with the scoreboard.
   initial begin : monitor
      logic [8:0] w, e;
      forever begin
         @(negedge sys_clk);
         if (!in_reset && wr_en) begin
            w = wr_data;
            writes++;
            if (cur_src < 0) begin
               if (ord_q.size() > 0) cur_src = ord_q.pop_front();
               else cur_src = int'(w[7]);
            end
            total++;
            if ((cur_src == 0 && exp0.size() == 0) || (cur_src != 0 && exp1.size() == 0)) begin
               bad++;
               $display("FAIL egress_unexpected got=%h port=%0d required=nothing", w, cur_src);
            end else begin
               if (cur_src == 0) e = exp0.pop_front(); else e = exp1.pop_front();
               if (w !== e) begin
                  bad++;
                  $display("FAIL egress_word port=%0d got=%h required=%h", cur_src, w, e);
               end
            end
            if (w == 9'h000) cur_src = -1;
         end
      end
   end

   initial begin : main
      int n, base_p, base_w;

      // Reset state
      sys_rst = 1'b0;
      repeat (3) @(posedge sys_clk);
      #3;
      chk("rst_rd0_en", 32'(rd0_en), 32'd0);
      chk("rst_rd1_en", 32'(rd1_en), 32'd0);
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      chk_counters("rst");
      sys_rst = 1'b1;
      in_reset = 1'b0;
      @(posedge sys_clk);
      #1;

      // PHY0 only: leading gap dropped, two bytes and terminator forwarded
      pops1 = 0;
      q0.push_back(9'h000); q0.push_back(9'h1AA); q0.push_back(9'h1BB); q0.push_back(9'h000);
      exp0.push_back(9'h1AA); exp0.push_back(9'h1BB); exp0.push_back(9'h000);
      ord_q.push_back(0);
      frm_exp0++;
      wait_drain("single");
      chk("single_rd1_pops", 32'(pops1), 32'd0);
      chk_counters("single");

      // Simultaneous frames: last grant was PHY0 -> PHY1 first ... then tie
      // resolution with PHY0 winning after a PHY1 grant.
      build_frame(0, 4); build_frame(1, 4);
      ord_q.push_back(1); ord_q.push_back(0);
      feed(0, 100); feed(1, 100);
      wait_drain("tie_a");
      chk_counters("tie_a");

      // PHY0 alone, then a tie -> PHY1 first
      build_frame(0, 3); ord_q.push_back(0); feed(0, 100);
      wait_drain("solo0");
      build_frame(0, 4); build_frame(1, 4);
      ord_q.push_back(1); ord_q.push_back(0);
      feed(0, 100); feed(1, 100);
      wait_drain("tie_b");
      // Both ports backlogged with two frames: strict alternation
      build_frame(0, 3); build_frame(0, 2); build_frame(1, 3); build_frame(1, 5);
      ord_q.push_back(1); ord_q.push_back(0); ord_q.push_back(1); ord_q.push_back(0);
      feed(0, 100); feed(1, 100);
      wait_drain("alternate");
      chk_counters("alternate");

      // Egress held full for 10 cycles mid-frame
      build_frame(0, 6); ord_q.push_back(0); feed(0, 100);
      n = 0;
      while (exp0.size() > 5 && n < 1000) begin @(posedge sys_clk); n++; end
      chk("full_start_timeout", 32'(n >= 1000), 32'd0);
      full_mode = 1;
      @(posedge sys_clk);
      #3;
      base_p = pops0; base_w = writes;
      repeat (10) @(posedge sys_clk);
      #3;
      chk("full_writes", 32'(writes - base_w), 32'd0);
      total++;
      if (pops0 - base_p > 2) begin
         bad++;
         $display("FAIL full_pops got=%0d required=at most 2", pops0 - base_p);
      end
      full_mode = 0;
      wait_drain("full");
      chk_counters("full");

      // Truncation on PHY1: above, at, and just below MAX_LEN
      build_frame(1, MAX_LEN + 3); build_frame(1, MAX_LEN); build_frame(1, MAX_LEN - 1);
      ord_q.push_back(1); ord_q.push_back(1); ord_q.push_back(1);
      feed(1, 100);
      wait_drain("trunc");
      chk_counters("trunc");

      // PHY0 stalls mid-frame while PHY1 requests
      build_frame(0, 5); build_frame(1, 3);
      ord_q.push_back(0); ord_q.push_back(1);
      feed(0, 2);
      n = 0;
      while (q0.size() != 0 && n < 1000) begin @(posedge sys_clk); n++; end
      chk("stall_start_timeout", 32'(n >= 1000), 32'd0);
      feed(1, 100);
      @(posedge sys_clk);
      #3;
      base_p = pops1;
      repeat (20) @(posedge sys_clk);
      #3;
      chk("stall_rd1_pops", 32'(pops1 - base_p), 32'd0);
      chk("stall_exp0_left", 32'(exp0.size()), 32'd4);
      feed(0, 100);
      wait_drain("stall");
      chk_counters("stall");

      // Randomized traffic with stalls and back-pressure
      rand_stall = 1'b1; full_mode = 2;
      for (int i = 0; i < 80; i++) begin
         n = int'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0) add_gaps(n, int'($urandom_range(1, 2)));
         build_frame(n, int'($urandom_range(1, MAX_LEN + 3)));
         feed(n, 100);
      end
      wait_drain("random");
      chk_counters("random");
      rand_stall = 1'b0; full_mode = 0;

      // Reset in the middle of a PHY1 frame
      build_frame(1, 7); ord_q.push_back(1); feed(1, 100);
      n = 0;
      while (exp1.size() > 5 && n < 1000) begin @(posedge sys_clk); n++; end
      chk("reset_start_timeout", 32'(n >= 1000), 32'd0);
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0; in_reset = 1'b1;
      @(posedge sys_clk);
      #3;
      chk("midrst_rd0_en", 32'(rd0_en), 32'd0);
      chk("midrst_rd1_en", 32'(rd1_en), 32'd0);
      chk("midrst_wr_en", 32'(wr_en), 32'd0);
      q0.delete(); q1.delete(); stage0.delete(); stage1.delete();
      exp0.delete(); exp1.delete(); ord_q.delete();
      cur_src = -1; frm_exp0 = 0; frm_exp1 = 0; trunc_exp = 0;
      chk_counters("midrst");
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b1; in_reset = 1'b0;
      @(posedge sys_clk);
      #1;

      // After reset PHY0 wins a tie again, then random traffic
      build_frame(0, 2); build_frame(1, 2);
      ord_q.push_back(0); ord_q.push_back(1);
      feed(0, 100); feed(1, 100);
      wait_drain("post_tie");
      rand_stall = 1'b1; full_mode = 2;
      for (int i = 0; i < 16; i++) begin
         n = int'($urandom_range(0, 1));
         build_frame(n, int'($urandom_range(1, MAX_LEN + 2)));
         feed(n, 100);
      end
      wait_drain("post_random");
      chk_counters("post");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_arbiter.md
Name: frame_arbiter

Overview:
- Merges the two PHY receive FIFOs into one shared egress FIFO, for example a host/CPU uplink.
- Grants at frame granularity with round-robin fairness, so frames are never interleaved.
- Uses the filter datapath's 9-bit word format: data[8]=1 is a frame byte; data[8]=0 is a gap/terminator word.
- Also discards idle gap words, truncates runaway frames, and keeps per-port frame counters.

Parameters:
- MAX_LEN, 1522: maximum frame bytes forwarded before forced truncation.
- LEN_W, 11: width of the per-frame byte counter; must hold MAX_LEN.
- CNT_W, 16: width of the statistics counters (wrap at 2^CNT_W).

Ports:
- sys_clk  in  1  single clock.
- sys_rst  in  1  reset, synchronous, active-low (0 = reset).
- rd0_en  out  1  pop strobe, PHY0 RX FIFO.
- rd0_data  in  9  head word, PHY0 RX FIFO (first-word-fall-through).
- rd0_empty  in  1  PHY0 RX FIFO empty.
- rd1_en  out  1  pop strobe, PHY1 RX FIFO.
- rd1_data  in  9  head word, PHY1 RX FIFO (FWFT).
- rd1_empty  in  1  PHY1 RX FIFO empty.
- wr_en  out  1  write strobe, egress FIFO.
- wr_data  out  9  egress word.
- wr_full  in  1  egress FIFO full.
- frm_cnt0  out  CNT_W  frames forwarded from PHY0.
- frm_cnt1  out  CNT_W  frames forwarded from PHY1.
- trunc_cnt  out  CNT_W  frames truncated by MAX_LEN, both ports.

Behaviour:
- Reset (sys_rst=0 at a clock edge):
  - state=IDLE, last_grant=1 (so PHY0 wins the first tie).
  - Skid buffer emptied; all counters 0.
  - rd0_en=rd1_en=wr_en=0, wr_data=0.
  - Reset mid-frame: the partial frame is abandoned (words in the skid are lost), no terminator is emitted, and the remainder is treated as gap/new data after reset.
- Input FIFOs are FWFT: rdN_data is valid whenever !rdN_empty, and rdN_en pops the head in that cycle.
  - rdN_en is only ever asserted with !rdN_empty.
- Output:
  - 2-entry skid FIFO of registered words.
  - wr_en = skid_nonempty & !wr_full; wr_data = skid head, or 0 when the skid is empty.
  - Latency: a word popped at cycle t is written to egress at t+1 if !wr_full.
- space = (skid_cnt<2) | wr_en.
  - Pops that forward a word require space.
  - Discarding pops (gap words, DISCARD state) ignore space.
- State IDLE:
  - For each port independently: if !empty and head[8]=0, pop and discard.
  - Ports with !empty and head[8]=1 are requesters.
  - One requester: grant it. Two requesters: grant !last_grant.
  - On grant: go to FWD(g), set last_grant=g, clear len=0.
  - No pop of frame bytes in the grant cycle.
- State FWD(g):
  - Each cycle that port g is !empty and space: pop.
  - Popped head[8]=1: push it, len+1.
    - If len+1 reaches MAX_LEN, go to TERM(g) with trunc pending.
  - Popped head[8]=0: push 9'h000 (terminator), increment frm_cntg, go to IDLE.
  - An empty FIFO mid-frame stalls; the MAX_LEN limit is in bytes, not cycles.
  - The non-granted port may still discard head[8]=0 words.
- State TERM(g): when space, push 9'h000, increment trunc_cnt (not frm_cntg), go to DISCARD(g).
- State DISCARD(g):
  - Pop port g while !empty, without forwarding, until a head[8]=0 word is popped; then go to IDLE.
  - Entering IDLE from DISCARD does not change last_grant.
- The egress stream therefore always consists of frame bytes, each frame followed by exactly one 9'h000.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package filter_pkg holds:
  - FRAME_BIT=8, WORD_W=9, TERM_WORD=9'h000.
  - state enum {IDLE, FWD, TERM, DISCARD} plus grant index.
- One natural sub-module, skid_fifo2: 2-entry, 9-bit register FIFO with push, pop, count and head outputs; it is reusable for the filter egress path.

Test Plan:
- PHY0 only: 0x000, 0x1AA, 0x1BB, 0x000, with wr_full=0 -> gap word discarded; egress 0x1AA, 0x1BB, 0x000; frm_cnt0=1; rd1_en never asserted.
- Both ports present a 4-byte frame in the same cycle after reset -> PHY0 frame forwarded whole, then PHY1's whole; next simultaneous pair -> PHY1 first; no interleaving.
- wr_full held 1 for 10 cycles mid-frame -> at most 2 words popped beyond the last write; no word lost or duplicated after release.
- MAX_LEN=4 build, PHY1 sends 7 bytes then 0x000 -> egress 4 bytes plus 0x000; remaining 3 bytes and the terminator are popped and dropped; trunc_cnt=1, frm_cnt1=0.
- PHY0 empties after 2 bytes for 20 cycles, then resumes -> FWD holds with no grant change even with PHY1 requesting; frame completes intact.
- sys_rst=0 asserted mid-frame -> next cycle rd*_en=0, wr_en=0, counters 0, state IDLE; new frames after release forwarded correctly.
